// File: rtl/max_stream_reduce_if.sv
// Valid/ready stream bundle for the max reduction stage: beat input side and frame result side.
interface max_stream_reduce_if #(
  parameter int unsigned W         = 4,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned IDX_W     = $clog2(FRAME_LEN),
  parameter int unsigned LEN_W     = $clog2(FRAME_LEN + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_max;
  logic [IDX_W-1:0] out_idx;
  logic [LEN_W-1:0] out_len;
  logic [7:0]       out_frame_id;

  // Upstream tiles and downstream collector as seen together from outside the stage
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_len, out_frame_id
  );

  // The reduction stage itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_len, out_frame_id
  );
endinterface

// File: rtl/max_stream_reduce.sv
// Reduces a frame of W-bit beats to its maximum, first-occurrence index, length and frame id.
module max_stream_reduce #(
  parameter int unsigned W         = 4,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  max_stream_reduce_if.slave    bus
);
  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam int unsigned LEN_W = $clog2(FRAME_LEN + 1);

  typedef enum logic {EMPTY, ACC} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     acc_max, acc_max_nxt;
  logic [IDX_W-1:0] acc_idx, acc_idx_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [7:0]       frame_cnt, frame_cnt_nxt;
  logic             res_valid, res_valid_nxt;
  logic [W-1:0]     res_max, res_max_nxt;
  logic [IDX_W-1:0] res_idx, res_idx_nxt;
  logic [LEN_W-1:0] res_len, res_len_nxt;
  logic [7:0]       res_id, res_id_nxt;

  logic             accept_c;
  logic             take_c;
  logic             done_c;
  logic [W-1:0]     beat_max_c;
  logic [IDX_W-1:0] beat_idx_c;

  // Input is open whenever the single result slot is free or being drained this cycle
  assign bus.in_ready = ~res_valid | bus.out_ready;
  assign accept_c     = bus.in_valid & bus.in_ready;

  assign bus.out_valid    = res_valid;
  assign bus.out_max      = res_max;
  assign bus.out_idx      = res_idx;
  assign bus.out_len      = res_len;
  assign bus.out_frame_id = res_id;

  // Next-state: accumulate accepted beats, close the frame on in_last or the final beat
  always_comb begin
    state_nxt     = state;
    acc_max_nxt   = acc_max;
    acc_idx_nxt   = acc_idx;
    cnt_nxt       = cnt;
    frame_cnt_nxt = frame_cnt;
    res_valid_nxt = res_valid;
    res_max_nxt   = res_max;
    res_idx_nxt   = res_idx;
    res_len_nxt   = res_len;
    res_id_nxt    = res_id;

    // Strict compare so ties keep the earlier index; the first beat always wins
    take_c     = (state == EMPTY) || (bus.in_data > acc_max);
    beat_max_c = take_c ? bus.in_data : acc_max;
    if (state == EMPTY) begin
      beat_idx_c = '0;
    end else begin
      beat_idx_c = take_c ? IDX_W'(cnt) : acc_idx;
    end
    done_c = bus.in_last || (cnt == LEN_W'(FRAME_LEN - 1));

    if (res_valid && bus.out_ready) begin
      res_valid_nxt = 1'b0;
    end

    if (accept_c) begin
      if (done_c) begin
        res_valid_nxt = 1'b1;
        res_max_nxt   = beat_max_c;
        res_idx_nxt   = beat_idx_c;
        res_len_nxt   = LEN_W'(cnt + LEN_W'(1));
        res_id_nxt    = frame_cnt;
        frame_cnt_nxt = frame_cnt + 8'd1;
        state_nxt     = EMPTY;
        cnt_nxt       = '0;
      end else begin
        state_nxt     = ACC;
        acc_max_nxt   = beat_max_c;
        acc_idx_nxt   = beat_idx_c;
        cnt_nxt       = LEN_W'(cnt + LEN_W'(1));
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      acc_max   <= '0;
      acc_idx   <= '0;
      cnt       <= '0;
      frame_cnt <= '0;
      res_valid <= 1'b0;
      res_max   <= '0;
      res_idx   <= '0;
      res_len   <= '0;
      res_id    <= '0;
    end else begin
      state     <= state_nxt;
      acc_max   <= acc_max_nxt;
      acc_idx   <= acc_idx_nxt;
      cnt       <= cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      res_valid <= res_valid_nxt;
      res_max   <= res_max_nxt;
      res_idx   <= res_idx_nxt;
      res_len   <= res_len_nxt;
      res_id    <= res_id_nxt;
    end
  end
endmodule
